// File: rtl/fifo_pkg.sv
// Shared constants for the 8x9 FIFO: geometry and controller state encoding.
// Kept as plain localparams so legacy consumers can compare raw state codes.
package fifo_pkg;

  localparam int FIFO_DEPTH = 8;
  localparam int FIFO_WIDTH = 9;
  localparam int FIFO_CNT_W = 4;

  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

endpackage

// File: rtl/fifo8x9_ctrl.sv
// Push/pop controller for the 8x9 FIFO storage block: same-cycle accept, occupancy tracking,
// rd_valid one cycle after an accepted pop, sticky overflow/underflow flags.
module fifo8x9_ctrl
  import fifo_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int CNT_W = FIFO_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clr,
  output logic             wren,
  output logic             WrInc,
  output logic             rden,
  output logic             RdInc,
  output logic             WrPtrClr,
  output logic             RdPtrClr,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic             rd_valid,
  output logic             ovf_err,
  output logic             udf_err
);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_count;
  logic             r_rd_valid;
  logic             r_ovf_err;
  logic             r_udf_err;

  logic w_run;
  logic w_req_ok;
  logic w_full;
  logic w_empty;
  logic w_wr_acc;
  logic w_rd_acc;

  assign w_run    = (r_state == ST_RUN);
  // A clr cycle neither accepts nor faults requests; the flush supersedes them.
  assign w_req_ok = w_run & ~clr;

  // Count is stale during FLUSH until the closing edge, so the flags are forced there.
  assign w_full   = w_run & (r_count == CNT_W'(DEPTH));
  assign w_empty  = ~w_run | (r_count == '0);

  assign w_wr_acc = w_req_ok & push & (~w_full | pop);
  assign w_rd_acc = w_req_ok & pop & ~w_empty;

  assign wren     = w_wr_acc;
  assign WrInc    = w_wr_acc;
  assign rden     = w_rd_acc;
  assign RdInc    = w_rd_acc;
  assign WrPtrClr = ~w_run;
  assign RdPtrClr = ~w_run;
  assign full     = w_full;
  assign empty    = w_empty;
  assign count    = r_count;
  assign rd_valid = r_rd_valid;
  assign ovf_err  = r_ovf_err;
  assign udf_err  = r_udf_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_INIT;
    end else begin
      case (r_state)
        ST_INIT:  r_state <= ST_RUN;
        ST_RUN:   r_state <= clr ? ST_FLUSH : ST_RUN;
        ST_FLUSH: r_state <= ST_RUN;
        default:  r_state <= ST_INIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !w_run) begin
      r_count <= '0;
    end else if (w_wr_acc && !w_rd_acc) begin
      r_count <= r_count + 1'b1;
    end else if (w_rd_acc && !w_wr_acc) begin
      r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_ovf_err  <= 1'b0;
      r_udf_err  <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_acc;
      r_ovf_err  <= r_ovf_err | (w_req_ok & push & ~w_wr_acc);
      r_udf_err  <= r_udf_err | (w_req_ok & pop & ~w_rd_acc);
    end
  end

endmodule

// File: tb/tb_fifo8x9_ctrl.sv
// Directed bench for fifo8x9_ctrl: inputs change on negedge, outputs checked mid-cycle or just after posedge.
module tb_fifo8x9_ctrl;

  logic       clk;
  logic       rst;
  logic       push;
  logic       pop;
  logic       clr;
  logic       wren;
  logic       WrInc;
  logic       rden;
  logic       RdInc;
  logic       WrPtrClr;
  logic       RdPtrClr;
  logic       full;
  logic       empty;
  logic [3:0] count;
  logic       rd_valid;
  logic       ovf_err;
  logic       udf_err;

  int n_cmp;
  int n_err;

  fifo8x9_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .clr      (clr),
    .wren     (wren),
    .WrInc    (WrInc),
    .rden     (rden),
    .RdInc    (RdInc),
    .WrPtrClr (WrPtrClr),
    .RdPtrClr (RdPtrClr),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .rd_valid (rd_valid),
    .ovf_err  (ovf_err),
    .udf_err  (udf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply inputs on negedge and let combinational outputs settle.
  task automatic drive(input logic p, input logic q, input logic c);
    @(negedge clk);
    push = p;
    pop  = q;
    clr  = c;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    push  = 1'b0;
    pop   = 1'b0;
    clr   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_rdv", rd_valid, 0);
    check("rst_errs", {ovf_err, udf_err}, 0);

    // 1: INIT clear cycle, then RUN
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("init_ptrclr", {WrPtrClr, RdPtrClr}, 2'b11);
    check("init_strobes", {wren, WrInc, rden, RdInc}, 0);
    tick();
    check("run_ptrclr", {WrPtrClr, RdPtrClr}, 2'b00);
    check("run_count", count, 0);
    check("run_flags", {empty, full}, 2'b10);
    check("run_errs", {ovf_err, udf_err}, 0);

    // 2: fill to 8, then overflow push
    for (int i = 1; i <= 8; i++) begin
      drive(1, 0, 0);
      check("fill_wren", {wren, WrInc}, 2'b11);
      tick();
      check("fill_count", count, i);
      check("fill_full", full, (i == 8) ? 1 : 0);
    end
    drive(1, 0, 0);
    check("ovf_wren", {wren, WrInc}, 2'b00);
    tick();
    check("ovf_flag", ovf_err, 1);
    check("ovf_count", count, 8);
    check("ovf_udf", udf_err, 0);

    // 3: push+pop while full
    drive(1, 1, 0);
    check("fullpp_strobes", {wren, rden}, 2'b11);
    tick();
    check("fullpp_count", count, 8);
    check("fullpp_rdv", rd_valid, 1);
    for (int i = 7; i >= 0; i--) begin
      drive(0, 1, 0);
      check("drain_rden", {rden, RdInc}, 2'b11);
      tick();
      check("drain_count", count, i);
      check("drain_rdv", rd_valid, 1);
    end
    check("drain_empty", empty, 1);
    check("drain_udf", udf_err, 0);

    // 4: push+pop while empty
    drive(1, 1, 0);
    check("emptypp_strobes", {wren, rden}, 2'b10);
    tick();
    check("emptypp_udf", udf_err, 1);
    check("emptypp_count", count, 1);
    check("emptypp_rdv", rd_valid, 0);

    // 5: clr at count 5 with push asserted
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0);
      tick();
    end
    check("pre_clr_count", count, 5);
    drive(1, 0, 1);
    check("clr_strobes", {wren, WrInc, rden, RdInc}, 0);
    check("clr_ptrclr", {WrPtrClr, RdPtrClr}, 2'b00);
    tick();
    drive(1, 1, 0);
    check("flush_ptrclr", {WrPtrClr, RdPtrClr}, 2'b11);
    check("flush_strobes", {wren, rden}, 0);
    check("flush_flags", {empty, full}, 2'b10);
    tick();
    check("postflush_count", count, 0);
    check("postflush_rdv", rd_valid, 0);
    check("postflush_errs", {ovf_err, udf_err}, 2'b11);
    check("postflush_ptrclr", WrPtrClr, 0);

    // 6: rst mid-operation with pop held
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0);
      tick();
    end
    check("pre_rst_count", count, 3);
    drive(0, 1, 0);
    rst = 1'b1;
    #1;
    tick();
    check("midrst_count", count, 0);
    check("midrst_rdv", rd_valid, 0);
    check("midrst_errs", {ovf_err, udf_err}, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reinit_ptrclr", {WrPtrClr, RdPtrClr}, 2'b11);
    check("reinit_rden", rden, 0);
    tick();
    check("rerun_ptrclr", WrPtrClr, 0);
    check("rerun_udf", udf_err, 0);
    check("rerun_rdv", rd_valid, 0);
    drive(0, 0, 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
